// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned DMEM_DATA_W = 19;
  localparam int unsigned DMEM_ADDR_W = 19;
  localparam int unsigned DMEM_DEPTH  = 256;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } dmem_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response handshakes for both requesters plus the memory port.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);
  logic              p0_req_valid, p1_req_valid;
  logic              p0_req_ready, p1_req_ready;
  logic              p0_req_we, p1_req_we;
  logic [ADDR_W-1:0] p0_req_addr, p1_req_addr;
  logic [DATA_W-1:0] p0_req_wdata, p1_req_wdata;
  logic              p0_rsp_valid, p1_rsp_valid;
  logic [DATA_W-1:0] p0_rsp_rdata, p1_rsp_rdata;
  logic              p0_rsp_err, p1_rsp_err;
  logic              mem_write, mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req_valid, p1_req_valid, p0_req_we, p1_req_we,
    input  p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
    output p0_req_ready, p1_req_ready,
    output p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata,
    output p0_rsp_err, p1_rsp_err,
    output mem_write, mem_read, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req_valid, p1_req_valid, p0_req_we, p1_req_we,
    output p0_req_addr, p1_req_addr, p0_req_wdata, p1_req_wdata,
    input  p0_req_ready, p1_req_ready,
    input  p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata,
    input  p0_rsp_err, p1_rsp_err,
    input  mem_write, mem_read, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_pick.sv
// Combinational 2-way grant. Macro DMEM_ARB_RR_EN selects round-robin
// (using the last-grant pointer); otherwise port 0 has fixed priority.
module dmem_arb_pick (
  input  logic [1:0] valid_i,
`ifdef DMEM_ARB_RR_EN
  input  logic       last_i,
`endif
  output logic [1:0] grant_o
);

`ifdef DMEM_ARB_RR_EN
  // On a tie, grant the port that did not win last time.
  always_comb begin
    grant_o = valid_i;
    if (&valid_i) begin
      grant_o = last_i ? 2'b01 : 2'b10;
    end
  end
`else
  // Port 0 always wins; port 1 only when port 0 is idle.
  always_comb begin
    grant_o    = 2'b00;
    grant_o[0] = valid_i[0];
    grant_o[1] = valid_i[1] & ~valid_i[0];
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 256-word data memory.
// One request per three cycles: accept (IDLE), memory strobe (ACCESS), response (RESP).
// Build option: DMEM_ARB_RR_EN enables round-robin arbitration.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DEPTH  = DMEM_DEPTH
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  dmem_state_e       state_q, state_d;
  logic              lat_we_q, lat_we_d;
  logic              lat_port_q, lat_port_d;
  logic              lat_oor_q, lat_oor_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [1:0]        grant;
  logic              win_port;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;

  dmem_arb_pick u_pick (
    .valid_i ({bus.p1_req_valid, bus.p0_req_valid}),
    .last_i  (last_q),
    .grant_o (grant)
  );
`else
  dmem_arb_pick u_pick (
    .valid_i ({bus.p1_req_valid, bus.p0_req_valid}),
    .grant_o (grant)
  );
`endif

  // Payload of the winning port.
  always_comb begin
    win_port  = grant[1] ? PORT_DMA : PORT_CPU;
    win_we    = grant[1] ? bus.p1_req_we    : bus.p0_req_we;
    win_addr  = grant[1] ? bus.p1_req_addr  : bus.p0_req_addr;
    win_wdata = grant[1] ? bus.p1_req_wdata : bus.p0_req_wdata;
  end

  // Next-state, latches and all bus outputs.
  always_comb begin
    state_d          = state_q;
    lat_we_d         = lat_we_q;
    lat_port_d       = lat_port_q;
    lat_oor_d        = lat_oor_q;
    lat_addr_d       = lat_addr_q;
    lat_wdata_d      = lat_wdata_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_err_d        = rsp_err_q;
`ifdef DMEM_ARB_RR_EN
    last_d           = last_q;
`endif
    bus.p0_req_ready = 1'b0;
    bus.p1_req_ready = 1'b0;
    bus.p0_rsp_valid = 1'b0;
    bus.p1_rsp_valid = 1'b0;
    bus.p0_rsp_rdata = '0;
    bus.p1_rsp_rdata = '0;
    bus.p0_rsp_err   = 1'b0;
    bus.p1_rsp_err   = 1'b0;
    bus.mem_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;

    unique case (state_q)
      StIdle: begin
        bus.p0_req_ready = grant[0];
        bus.p1_req_ready = grant[1];
        if (|grant) begin
          lat_we_d    = win_we;
          lat_port_d  = win_port;
          lat_addr_d  = win_addr;
          lat_wdata_d = win_wdata;
          lat_oor_d   = 32'(win_addr) >= DEPTH;
`ifdef DMEM_ARB_RR_EN
          last_d      = win_port;
`endif
          state_d     = StAccess;
        end
      end
      StAccess: begin
        bus.mem_addr  = lat_addr_q;
        bus.mem_wdata = lat_wdata_q;
        bus.mem_write = ~lat_oor_q & lat_we_q;
        bus.mem_read  = ~lat_oor_q & ~lat_we_q;
        // Writes and range errors report zero data.
        rsp_rdata_d   = (lat_we_q | lat_oor_q) ? '0 : bus.mem_rdata;
        rsp_err_d     = lat_oor_q;
        state_d       = StResp;
      end
      StResp: begin
        if (lat_port_q == PORT_DMA) begin
          bus.p1_rsp_valid = 1'b1;
          bus.p1_rsp_rdata = rsp_rdata_q;
          bus.p1_rsp_err   = rsp_err_q;
        end else begin
          bus.p0_rsp_valid = 1'b1;
          bus.p0_rsp_rdata = rsp_rdata_q;
          bus.p0_rsp_err   = rsp_err_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State, request latch and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lat_we_q    <= 1'b0;
      lat_port_q  <= PORT_CPU;
      lat_oor_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_we_q    <= lat_we_d;
      lat_port_q  <= lat_port_d;
      lat_oor_q   <= lat_oor_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // Last-grant pointer; resets to port 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT_DMA;
    end else begin
      last_q <= last_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table of single transactions plus
// hand-written arbitration, held-valid and reset-during-access sequences.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: combinational read, write on rising edge.
  logic [18:0] mem [256];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

  typedef struct {
    logic        port;
    logic        we;
    logic [18:0] addr;
    logic [18:0] wdata;
    logic [18:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic v, input logic we, input logic [18:0] a,
                       input logic [18:0] d);
    if (p) begin
      bus.p1_req_valid = v; bus.p1_req_we = we; bus.p1_req_addr = a; bus.p1_req_wdata = d;
    end else begin
      bus.p0_req_valid = v; bus.p0_req_we = we; bus.p0_req_addr = a; bus.p0_req_wdata = d;
    end
  endtask

  function automatic logic rdy(input logic p);
    return p ? bus.p1_req_ready : bus.p0_req_ready;
  endfunction
  function automatic logic rvld(input logic p);
    return p ? bus.p1_rsp_valid : bus.p0_rsp_valid;
  endfunction
  function automatic logic [18:0] rdat(input logic p);
    return p ? bus.p1_rsp_rdata : bus.p0_rsp_rdata;
  endfunction
  function automatic logic rerr(input logic p);
    return p ? bus.p1_rsp_err : bus.p0_rsp_err;
  endfunction

  // One complete transaction from an IDLE cycle; returns in the next IDLE cycle.
  task automatic do_txn(input string tag, input vec_t v);
    logic ok;
    ok = ~v.exp_err;
    drive(v.port, 1'b1, v.we, v.addr, v.wdata);
    #1;
    chk({tag, ".ready"}, 32'(rdy(v.port)), 32'd1);
    chk({tag, ".other_ready"}, 32'(rdy(~v.port)), 32'd0);
    @(posedge clk); #1;
    drive(v.port, 1'b0, 1'b0, 19'd0, 19'd0);
    chk({tag, ".mem_write"}, 32'(bus.mem_write), 32'(v.we & ok));
    chk({tag, ".mem_read"}, 32'(bus.mem_read), 32'(~v.we & ok));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(v.addr));
    chk({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(v.wdata));
    chk({tag, ".acc_rsp_valid"}, 32'(rvld(v.port)), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rsp_valid"}, 32'(rvld(v.port)), 32'd1);
    chk({tag, ".other_rsp_valid"}, 32'(rvld(~v.port)), 32'd0);
    chk({tag, ".rsp_rdata"}, 32'(rdat(v.port)), 32'(v.exp_rdata));
    chk({tag, ".rsp_err"}, 32'(rerr(v.port)), 32'(v.exp_err));
    chk({tag, ".resp_mem_write"}, 32'(bus.mem_write), 32'd0);
    chk({tag, ".resp_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rsp_done"}, 32'(rvld(v.port)), 32'd0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  vec_t vecs [9];
  vec_t tv;
  logic exp_order [8];
  logic g0, g1;
  int   c0, c1, ng, last_cyc;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 19'h00010, 19'h5A5A5, 19'h00000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 19'h00010, 19'h00000, 19'h5A5A5, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 19'h00100, 19'h00000, 19'h00000, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 19'h00020, 19'h12345, 19'h00000, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 19'h00020, 19'h00000, 19'h12345, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 19'h000FF, 19'h7FFFF, 19'h00000, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 19'h000FF, 19'h00000, 19'h7FFFF, 1'b0};
    // Out-of-range write aliasing 0x10 in the model must not reach memory.
    vecs[7] = '{1'b1, 1'b1, 19'h00110, 19'h33333, 19'h00000, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 19'h00010, 19'h00000, 19'h5A5A5, 1'b0};

    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);

    // Reset values.
    #12;
    chk("rst.p0_ready", 32'(bus.p0_req_ready), 32'd0);
    chk("rst.p1_ready", 32'(bus.p1_req_ready), 32'd0);
    chk("rst.rsp_valid", 32'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 32'd0);
    chk("rst.rsp_err", 32'({bus.p0_rsp_err, bus.p1_rsp_err}), 32'd0);
    chk("rst.strobes", 32'({bus.mem_write, bus.mem_read}), 32'd0);
    chk("rst.mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst.mem_wdata", 32'(bus.mem_wdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) do_txn($sformatf("vec%0d", i), vecs[i]);

    // Simultaneous valids, four writes per port.
    pulse_reset();
`ifdef DMEM_ARB_RR_EN
    for (int i = 0; i < 8; i++) exp_order[i] = i[0];
`else
    for (int i = 0; i < 8; i++) exp_order[i] = (i >= 4);
`endif
    c0 = 0; c1 = 0; ng = 0; last_cyc = 0;
    drive(1'b0, 1'b1, 1'b1, 19'h40, 19'h01000);
    drive(1'b1, 1'b1, 1'b1, 19'h50, 19'h02000);
    for (int cyc = 0; cyc < 60 && ng < 8; cyc++) begin
      #1;
      g0 = bus.p0_req_valid & bus.p0_req_ready;
      g1 = bus.p1_req_valid & bus.p1_req_ready;
      if (g0 | g1) begin
        chk($sformatf("tie.grant%0d", ng), 32'({g1, g0}), exp_order[ng] ? 32'd2 : 32'd1);
        if (ng > 0) chk($sformatf("tie.gap%0d", ng), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        ng++;
      end
      @(posedge clk); #1;
      if (g0) begin
        c0++;
        drive(1'b0, c0 < 4, 1'b1, 19'(32'h40 + c0), 19'(32'h1000 + c0));
      end
      if (g1) begin
        c1++;
        drive(1'b1, c1 < 4, 1'b1, 19'(32'h50 + c1), 19'(32'h2000 + c1));
      end
    end
    chk("tie.total", 32'(ng), 32'd8);
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
    repeat (3) @(posedge clk);
    #1;
    tv = '{1'b0, 1'b0, 19'h00053, 19'h0, 19'h02003, 1'b0};
    do_txn("tie.rd53", tv);
    tv = '{1'b1, 1'b0, 19'h00043, 19'h0, 19'h01003, 1'b0};
    do_txn("tie.rd43", tv);

    // Held valid on port 1 while port 0 is served.
    drive(1'b0, 1'b1, 1'b1, 19'h30, 19'h2AAAA);
    drive(1'b1, 1'b1, 1'b0, 19'h10, 19'h0);
    #1;
    chk("hold.idle_p0_ready", 32'(bus.p0_req_ready), 32'd1);
    chk("hold.idle_p1_ready", 32'(bus.p1_req_ready), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("hold.access_p1_ready", 32'(bus.p1_req_ready), 32'd0);
    @(posedge clk); #1;
    chk("hold.resp_p1_ready", 32'(bus.p1_req_ready), 32'd0);
    chk("hold.resp_p0_valid", 32'(bus.p0_rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("hold.idle2_p1_ready", 32'(bus.p1_req_ready), 32'd1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("hold.p1_mem_read", 32'(bus.mem_read), 32'd1);
    @(posedge clk); #1;
    chk("hold.p1_rsp_valid", 32'(bus.p1_rsp_valid), 32'd1);
    chk("hold.p1_rsp_rdata", 32'(bus.p1_rsp_rdata), 32'h5A5A5);
    @(posedge clk); #1;
    tv = '{1'b1, 1'b0, 19'h00030, 19'h0, 19'h2AAAA, 1'b0};
    do_txn("hold.rd30", tv);

    // Reset asserted during ACCESS of a write.
    drive(1'b0, 1'b1, 1'b1, 19'h20, 19'h7FFFF);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 19'd0, 19'd0);
    chk("rstacc.mem_write_before", 32'(bus.mem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstacc.mem_write_async", 32'(bus.mem_write), 32'd0);
    chk("rstacc.mem_addr_async", 32'(bus.mem_addr), 32'd0);
    chk("rstacc.mem_wdata_async", 32'(bus.mem_wdata), 32'd0);
    @(posedge clk); #1;
    chk("rstacc.rsp_in_reset", 32'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rstacc.no_rsp%0d", i), 32'({bus.p0_rsp_valid, bus.p1_rsp_valid}), 32'd0);
    end
    tv = '{1'b0, 1'b0, 19'h00020, 19'h0, 19'h12345, 1'b0};
    do_txn("rstacc.rd20", tv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the 19-bit CPU's 256-word data memory. It shares the single memory port between the CPU load/store unit (port 0) and the DMA/debug loader (port 1). It accepts one request at a time over a valid/ready handshake, drives the memory's write/read strobes for exactly one cycle, and returns a registered response with range-error reporting.

## Interface
Parameters:
- DATA_W, 19, data word width
- ADDR_W, 19, address width
- DEPTH, 256, number of implemented memory words; addresses ≥ DEPTH are out of range

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- p0_req_valid / p1_req_valid  in  1  request present
- p0_req_ready / p1_req_ready  out  1  request accepted this cycle when high with valid
- p0_req_we / p1_req_we  in  1  1 = write, 0 = read
- p0_req_addr / p1_req_addr  in  ADDR_W  word address
- p0_req_wdata / p1_req_wdata  in  DATA_W  write data
- p0_rsp_valid / p1_rsp_valid  out  1  one-cycle response pulse
- p0_rsp_rdata / p1_rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- p0_rsp_err / p1_rsp_err  out  1  address out of range
- mem_write  out  1  to memory write strobe
- mem_read  out  1  to memory read enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory, combinational read data

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Arbitrate among asserted req_valid.
  - Assert req_ready for the winner only; ready is combinational from valids and state.
  - On accept, latch we/addr/wdata/port id and the range flag (addr ≥ DEPTH) → ACCESS.
  - No valid → stay in IDLE.
- ACCESS (one cycle):
  - mem_addr and mem_wdata come from the latch.
  - If in range: mem_write = we, mem_read = !we.
  - If out of range: both strobes stay 0.
  - Capture mem_rdata into the response register on the closing edge.
  - The write commits on that same edge.
  - → RESP.
- RESP (one cycle):
  - Assert rsp_valid for the latched port only, with rdata and err.
  - rdata = 0 for writes and out-of-range accesses.
  - → IDLE.
- Responses have no backpressure; requesters must sample on the pulse.
- req_ready = 0 in ACCESS and RESP. A requester holds valid and payload until ready.
- mem_addr and mem_wdata are 0 whenever not in ACCESS.
- The non-granted port's valid is ignored until the next IDLE cycle. No request is lost.

## Timing
- Accept at cycle T → memory access at T+1 → rsp_valid at T+2. Next accept no earlier than T+3.
- Peak throughput: one access per 3 cycles.
- Reset values: all req_ready, rsp_valid, rsp_err, mem_write, mem_read = 0; all data/address outputs = 0; state = IDLE.
- Reset asserted mid-operation:
  - Immediately returns to IDLE and drops the strobes.
  - An in-flight request is discarded with no response.
  - A write is not committed unless the ACCESS closing edge occurred before reset.
- Simultaneous valids are resolved per Configuration. The loser waits exactly one transaction (3 cycles) under round-robin.

## Configuration
- DMEM_ARB_RR_EN defined:
  - Round-robin with a last-grant pointer, updated on each accept.
  - Reset value of the pointer = 1, so port 0 wins the first tie.
- DMEM_ARB_RR_EN undefined:
  - Fixed priority, port 0 always wins ties.
  - No pointer register.
  - Port 1 can starve under continuous port 0 traffic.

## Structure
- Package dmem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RESP)
  - DATA_W, ADDR_W and DEPTH default constants
  - port-id constants PORT_CPU = 0, PORT_DMA = 1
- One sub-module, dmem_arb_pick:
  - Combinational 2-way grant from valids and pointer.
  - Contains the DMEM_ARB_RR_EN-selected logic.
- The FSM, latches and response registers stay in dmem_arbiter.

## Test plan
- Write then read on port 0:
  - Stimulus: write addr 0x00010 = 0x5A5A5, then read the same address.
  - Response: mem_write high for exactly one cycle at T+1; read rsp_valid at T+2 with rdata 0x5A5A5 and err = 0.
- Out-of-range access on port 1:
  - Stimulus: p1 read at addr 0x00100.
  - Response: no mem strobes; p1_rsp_valid with err = 1 and rdata = 0.
- Simultaneous valids, 4 back-to-back requests per port:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without it: all four port-0 requests are served before port 1.
- Held-valid compliance:
  - Stimulus: p1 holds valid while p0 is granted.
  - Response: p1_req_ready = 0 during ACCESS and RESP; p1 is accepted in the next IDLE.
- Reset during ACCESS of a write (addr 0x20 = 0x7FFFF):
  - Response: strobes drop asynchronously; no rsp_valid.
  - A subsequent read of 0x20 returns the prior value.
